// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - single-port instruction memory arbiter between IF fetch and burst loader
// The loader holds the port for a locked burst; after MAX_BURST writes one slot is forced back to IF.

module imem_port_arbiter #(
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic [DW-1:0] o_if_rdata,
   output logic          o_if_rvalid,
   output logic          o_if_stall,
   input  logic          i_ld_req,
   input  logic [AW-1:0] i_ld_addr,
   input  logic [DW-1:0] i_ld_wdata,
   input  logic          i_ld_last,
   output logic          o_ld_gnt,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      LOAD  = 2'd1,
      YIELD = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_burst_cnt;
   logic [CW-1:0] w_burst_cnt_nxt;
   logic          w_ld_owner;
   logic [DW-1:0] r_if_rdata;
   logic          r_if_rvalid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= FETCH;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   // ld_last takes priority over the forced IF slot
   always_comb begin
      w_state_nxt     = r_state;
      w_burst_cnt_nxt = r_burst_cnt;
      unique case (r_state)
         FETCH: begin
            if (i_ld_req) w_state_nxt = LOAD;
         end
         LOAD: begin
            if (i_ld_req) begin
               if (i_ld_last) begin
                  w_state_nxt     = FETCH;
                  w_burst_cnt_nxt = '0;
               end else if (r_burst_cnt == CW'(MAX_BURST - 1)) begin
                  w_state_nxt     = YIELD;
                  w_burst_cnt_nxt = '0;
               end else begin
                  w_burst_cnt_nxt = r_burst_cnt + 1'b1;
               end
            end
         end
         YIELD: begin
            w_state_nxt = LOAD;
         end
         default: begin
            w_state_nxt     = FETCH;
            w_burst_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_ld_owner  = (r_state == LOAD);
      o_ld_gnt    = w_ld_owner & i_ld_req;
      o_if_stall  = w_ld_owner & i_if_req;
      o_mem_en    = w_ld_owner ? i_ld_req : i_if_req;
      o_mem_we    = w_ld_owner & i_ld_req;
      o_mem_addr  = w_ld_owner ? i_ld_addr : i_if_addr;
      o_mem_wdata = i_ld_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_if_rdata  <= '0;
         r_if_rvalid <= 1'b0;
      end else if (!w_ld_owner) begin
         r_if_rvalid <= i_if_req;
         if (i_if_req) r_if_rdata <= i_mem_rdata;
      end else begin
         r_if_rvalid <= 1'b0;
      end
   end

   assign o_if_rdata  = r_if_rdata;
   assign o_if_rvalid = r_if_rvalid;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench for imem_port_arbiter
// Directed vector table, hand-written burst sequences and random traffic against a burst-level model.

module tb_imem_port_arbiter;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int MAXB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_rvalid;
   logic          if_stall;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_last;
   logic          ld_gnt;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] tb_mem [2**AW];
   assign mem_rdata = tb_mem[mem_addr];

   always #5 clk = ~clk;

   imem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
      .o_if_rvalid(if_rvalid), .o_if_stall(if_stall),
      .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
      .i_ld_last(ld_last), .o_ld_gnt(ld_gnt),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   int n_vec = 0;
   int n_err = 0;

   // model: burst-level view of who owns the port
   bit            m_in_burst;
   bit            m_yield;
   int            m_run;
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;
   logic [DW-1:0] m_mem [2**AW];

   logic          s_gnt, s_stall, s_en, s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;

   typedef struct {
      logic          ir;
      logic [AW-1:0] ia;
      logic          lr;
      logic [AW-1:0] la;
      logic [DW-1:0] lw;
      logic          ll;
      logic          e_gnt;
      logic          e_stall;
      logic          e_en;
      logic          e_we;
      logic          e_rvalid;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_burst = 0;
      m_yield    = 0;
      m_run      = 0;
      m_rdata    = '0;
      m_rvalid   = 1'b0;
   endtask

   task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic lr,
                        input logic [AW-1:0] la, input logic [DW-1:0] lw, input logic ll);
      bit loader;
      @(negedge clk);
      if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la; ld_wdata = lw; ld_last = ll;
      #1;
      s_gnt = ld_gnt; s_stall = if_stall; s_en = mem_en; s_we = mem_we;
      s_addr = mem_addr; s_wdata = mem_wdata;
      loader = m_in_burst && !m_yield;
      chk("ld_gnt", {31'b0, s_gnt}, {31'b0, loader & lr});
      chk("if_stall", {31'b0, s_stall}, {31'b0, loader & ir});
      chk("mem_en", {31'b0, s_en}, {31'b0, loader ? lr : ir});
      chk("mem_we", {31'b0, s_we}, {31'b0, loader & lr});
      chk("mem_addr", {27'b0, s_addr}, {27'b0, loader ? la : ia});
      if (loader && lr) chk("mem_wdata", s_wdata, lw);
      if (!loader) begin
         m_rvalid = ir;
         if (ir) m_rdata = m_mem[ia];
      end else begin
         m_rvalid = 1'b0;
         if (lr) m_mem[la] = lw;
      end
      if (m_yield) m_yield = 0;
      else if (!m_in_burst) begin
         if (lr) begin m_in_burst = 1; m_run = 0; end
      end else if (lr) begin
         m_run++;
         if (ll) m_in_burst = 0;
         else if (m_run == MAXB) begin m_yield = 1; m_run = 0; end
      end
      @(posedge clk);
      if (s_en && s_we) tb_mem[s_addr] = s_wdata;
      #1;
      chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, m_rvalid});
      chk("if_rdata", if_rdata, m_rdata);
   endtask

   initial begin
      int k, nc;
      int yq[$];
      rst_n = 1'b0; if_req = 0; if_addr = 0; ld_req = 0; ld_addr = 0; ld_wdata = 0; ld_last = 0;
      for (int i = 0; i < 2**AW; i++) begin
         tb_mem[i] = $urandom;
         m_mem[i]  = tb_mem[i];
      end
      tb_mem[3] = 32'hDEADBEEF;
      m_mem[3]  = 32'hDEADBEEF;
      model_reset();

      vecs[0] = '{1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 5'd3, 1'b1, 5'd0, 32'hA0A00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd3, 1'b1, 5'd0, 32'hA0A00000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd3, 1'b1, 5'd1, 32'hA0A00001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[4] = '{1'b1, 5'd3, 1'b1, 5'd2, 32'hA0A00002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[5] = '{1'b1, 5'd3, 1'b1, 5'd3, 32'hA0A00003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 5'd2, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0A00002};
      vecs[7] = '{1'b0, 5'd2, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0A00002};

      repeat (2) @(negedge clk);
      chk("reset_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("reset_rdata", if_rdata, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].ir, vecs[i].ia, vecs[i].lr, vecs[i].la, vecs[i].lw, vecs[i].ll);
         chk($sformatf("vec%0d_gnt", i), {31'b0, s_gnt}, {31'b0, vecs[i].e_gnt});
         chk($sformatf("vec%0d_stall", i), {31'b0, s_stall}, {31'b0, vecs[i].e_stall});
         chk($sformatf("vec%0d_en", i), {31'b0, s_en}, {31'b0, vecs[i].e_en});
         chk($sformatf("vec%0d_we", i), {31'b0, s_we}, {31'b0, vecs[i].e_we});
         chk($sformatf("vec%0d_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].e_rvalid});
         chk($sformatf("vec%0d_rdata", i), if_rdata, vecs[i].e_rdata);
      end

      // 20-word continuous burst: forced IF slots after the 8th and 16th writes
      cycle(1'b1, 5'd7, 1'b1, 5'd0, 32'h0, 1'b0);
      k = 0; nc = 0;
      while (k < 20 && nc < 40) begin
         cycle(1'b1, AW'($urandom), 1'b1, AW'(k), 32'hB0000000 + k, k == 19);
         nc++;
         if (s_gnt) k++;
         else begin
            yq.push_back(k);
            chk("yield_stall", {31'b0, s_stall}, 32'd0);
         end
      end
      chk("burst20_cycles", nc, 22);
      chk("burst20_nyield", yq.size(), 2);
      if (yq.size() == 2) begin
         chk("yield0_pos", yq[0], 8);
         chk("yield1_pos", yq[1], 16);
      end

      // pause mid-burst: count must freeze across the gap
      cycle(1'b1, 5'd1, 1'b1, 5'd8, 32'hC0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 5'd1, 1'b1, AW'(8 + i), 32'hC0 + i, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0);
         chk("pause_en", {31'b0, s_en}, 32'd0);
         chk("pause_stall", {31'b0, s_stall}, 32'd1);
      end
      for (int i = 5; i < 8; i++) begin
         cycle(1'b1, 5'd1, 1'b1, AW'(8 + i), 32'hC0 + i, 1'b0);
         chk("resume_gnt", {31'b0, s_gnt}, 32'd1);
      end
      cycle(1'b1, 5'd1, 1'b1, 5'd16, 32'hC8, 1'b0);
      chk("pause_yield_gnt", {31'b0, s_gnt}, 32'd0);
      chk("pause_yield_stall", {31'b0, s_stall}, 32'd0);
      cycle(1'b1, 5'd1, 1'b1, 5'd16, 32'hC8, 1'b1);

      // asynchronous reset in the middle of a burst
      cycle(1'b0, 5'd0, 1'b1, 5'd20, 32'hD0, 1'b0);
      cycle(1'b1, 5'd0, 1'b1, 5'd20, 32'hD0, 1'b0);
      cycle(1'b1, 5'd0, 1'b1, 5'd21, 32'hD1, 1'b0);
      @(negedge clk);
      ld_addr = 5'd22; ld_wdata = 32'hD2; #1;
      chk("pre_rst_gnt", {31'b0, ld_gnt}, 32'd1);
      rst_n = 1'b0; #1;
      chk("rst_gnt", {31'b0, ld_gnt}, 32'd0);
      chk("rst_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("rst_rdata", if_rdata, 32'd0);
      chk("rst_stall", {31'b0, if_stall}, 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(1'b1, 5'd21, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("post_rst_en", {31'b0, s_en}, 32'd1);
      chk("post_rst_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("post_rst_rdata", if_rdata, 32'hD1);

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 2) != 0,
               AW'($urandom), $urandom, $urandom_range(0, 5) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
